// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller.
// Stall vectors are indexed [0] PC .. [5] WB; a set bit holds that stage register.
package pipe_ctrl_pkg;

    localparam int          CNT_W_DEF      = 6;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] EXC_ERET       = 32'h0000_000e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        RUN = 1'b0,
        MC  = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges ID/EX/MEM stall requests, sequences multi-cycle EX ops, issues flush/redirect.
// Latency: stall/flush/new_pc/ex_mc_done are combinational; busy changes one clk edge after start/abort.
// Backpressure: a pending MEM access freezes the controller and defers any MEM-stage exception.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_mem,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_len,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             ex_mc_done,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             exc_take;
    logic [5:0]       id_stall;

    assign exc_take = (excepttype != 32'h0) && !stallreq_mem;
    assign id_stall = stallreq_id ? STALL_ID : STALL_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = 32'h0;
        ex_mc_done = 1'b0;

        // Reset forces every output quiet; the register block handles state.
        if (!rst) begin
            if (exc_take) begin
                flush     = 1'b1;
                new_pc    = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else if (stallreq_mem) begin
                stall = STALL_MEM;
            end else if (state == MC) begin
                if (cnt != '0) begin
                    stall   = STALL_EX;
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    ex_mc_done = 1'b1;
                    state_nxt  = RUN;
                    stall      = id_stall;
                end
            end else if (ex_mc_start) begin
                // The issue cycle counts toward the length, so MC waits len-2 more stalled cycles.
                if (ex_mc_len <= CNT_W'(1)) begin
                    ex_mc_done = 1'b1;
                    stall      = id_stall;
                end else begin
                    stall     = STALL_EX;
                    cnt_nxt   = ex_mc_len - CNT_W'(2);
                    state_nxt = MC;
                end
            end else begin
                stall = id_stall;
            end
        end
    end

    assign busy = (state == MC) && !rst;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the five-stage core. Arbitrates stall requests from ID, EX and MEM into one per-stage stall vector. Sequences multi-cycle EX operations with an internal down-counter. Issues pipeline flush and redirect PC when MEM reports an exception or ERET. It sits beside the stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and drives their hold and flush inputs.

## Interface
- EXC_VECTOR, 32'h0000_0020, redirect PC for any non-ERET exception
- CNT_W, 6, width of multi-cycle length and counter

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_id  in  1  ID needs one more cycle (load-use)
- stallreq_mem  in  1  MEM bus access not complete
- ex_mc_start  in  1  EX is issuing a multi-cycle op this cycle
- ex_mc_len  in  CNT_W  total EX cycles of that op, including the issue cycle
- excepttype  in  32  MEM-stage exception code; 0 means none
- cp0_epc  in  32  EPC value from CP0
- stall  out  6  hold bits: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
- flush  out  1  clear all stage registers this cycle
- new_pc  out  32  redirect target, valid when flush=1
- ex_mc_done  out  1  one-cycle pulse: multi-cycle result valid in EX this cycle
- busy  out  1  multi-cycle op in progress (state MC)

## Operation
- State register has states RUN and MC. The CNT_W-bit counter cnt holds the remaining EX stall cycles.
- stall, flush, new_pc and ex_mc_done are combinational from state, cnt and inputs. busy is state==MC.
- Events in priority order; the first match wins:
  1. Exception accepted when excepttype!=0 and stallreq_mem=0.
     - Outputs: flush=1, stall=0, ex_mc_done=0.
     - new_pc = cp0_epc if excepttype==32'h0000_000e (ERET), else EXC_VECTOR.
     - Next state RUN, cnt<=0. ex_mc_start is ignored this cycle.
  2. stallreq_mem=1.
     - stall=6'b011111. State and cnt frozen. ex_mc_done=0. ex_mc_start is ignored.
  3. State MC.
     - cnt!=0: stall=6'b001111, cnt<=cnt-1.
     - cnt==0: ex_mc_done=1, state<=RUN. stall comes from stallreq_id: 6'b000111 if set, else 0.
  4. State RUN with ex_mc_start=1.
     - ex_mc_len<=1: ex_mc_done=1 this cycle, no EX stall, stay in RUN.
     - ex_mc_len>=2: stall=6'b001111, cnt<=ex_mc_len-2, state<=MC.
  5. Otherwise: stall=6'b000111 if stallreq_id, else 6'b000000.
- An op of length L therefore stalls EX for L-1 cycles and asserts ex_mc_done in its L-th unstalled cycle.
- excepttype!=0 while stallreq_mem=1 is not accepted. It is taken on the first cycle stallreq_mem drops, provided excepttype is still nonzero.
- ex_mc_start while in MC is ignored, since EX is stalled and cannot issue.

## Timing
- Reset (rst=1 at a clk edge): state<=RUN, cnt<=0.
- While rst=1, outputs are forced: stall=0, flush=0, new_pc=0, ex_mc_done=0, busy=0.
- Reset mid-MC abandons the op; no done pulse is produced.
- Zero-cycle latency from requests to stall/flush. One clock edge from start/abort to busy change.
- cnt never underflows: it decrements only when nonzero and not frozen.

## Structure
- Shared package holds:
  - stall vector constants STALL_NONE, STALL_ID, STALL_EX, STALL_MEM
  - EXC_ERET code 32'h0000_000e
  - default EXC_VECTOR
  - state enum {RUN, MC}
- Single module. The counter is small enough that no sub-module is warranted.

## Test plan
- Reset: hold rst 2 cycles with all requests active -> stall=0, flush=0, busy=0. After release with no requests -> stall=000000.
- ID stall: stallreq_id=1 for 1 cycle -> stall=000111 that cycle only. Then set stallreq_id and stallreq_mem together -> stall=011111.
- Multi-cycle len=4: pulse ex_mc_start at cycle c -> stall=001111 in cycles c..c+2, ex_mc_done=1 and stall=0 at c+3, busy=1 during c+1..c+3. With len=1 -> ex_mc_done=1 in cycle c, no stall.
- MEM stall freezes counter: len=4 at c, stallreq_mem=1 during c+1..c+2 -> stall=011111 in those cycles, ex_mc_done moves to c+5.
- Exception aborts MC: len=10, excepttype=32'h1 at c+3 -> flush=1, new_pc=32'h20, stall=0 at c+3. busy=0 from c+4, and no ex_mc_done afterwards.
- ERET gated by MEM: excepttype=32'he, cp0_epc=32'h1234, stallreq_mem=1 for 2 cycles -> flush=0 for those 2 cycles, then flush=1 with new_pc=32'h1234 on the first cycle stallreq_mem=0.
